// File: rtl/float_add_sequencer.sv
// float_add_sequencer
//   Issue stage that sits directly in front of a registered floating-point adder.
//   Operand pairs from the core are buffered in a small FIFO. Pairs with a zero,
//   Inf or NaN operand are resolved here and never reach the adder. Every other
//   pair gets a one-cycle adder enable, and the adder's registered result is
//   captured on the following cycle.
//
// Ports
//   clk, rst                  rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready         operand push handshake; in_ready = (count < DEPTH)
//   in_a, in_b, in_sub, in_tag  operand pair (IEEE-754 single), subtract flag, tag
//   fa_a, fa_b, fa_negate     registered adder operands (held outside ISSUE)
//   fa_enable                 adder enable, high only in ISSUE
//   fa_out                    adder registered result, sampled only in CAPTURE
//   res_valid/res_ready       result handshake
//   res_data, res_tag, res_special  result word, echoed tag, special-path flag
//   count                     FIFO occupancy
//   state_dbg                 current FSM state (IDLE=0 ISSUE=1 CAPTURE=2 HOLD=3)
//
// Handshakes: a transfer happens on a rising edge where valid & ready are both
//   high. A producer holding valid keeps its payload stable until the transfer;
//   ready may change freely and has no effect unless valid is also high.

module float_add_sequencer #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_a,
  input  logic [31:0]              in_b,
  input  logic                     in_sub,
  input  logic [TAG_W-1:0]         in_tag,
  output logic [31:0]              fa_a,
  output logic [31:0]              fa_b,
  output logic                     fa_negate,
  output logic                     fa_enable,
  input  logic [31:0]              fa_out,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [31:0]              res_data,
  output logic [TAG_W-1:0]         res_tag,
  output logic                     res_special,
  output logic [$clog2(DEPTH):0]   count,
  output logic [1:0]               state_dbg
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [31:0]      QNAN     = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } state_t;

  typedef struct packed {
    logic [31:0]      a;
    logic [31:0]      b;
    logic             sub;
    logic [TAG_W-1:0] tag;
  } entry_t;

  state_t           state, state_next;
  entry_t           mem [DEPTH];
  entry_t           head;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             push, pop;
  logic             head_nan, head_a_zero, head_b_zero, head_special;
  logic [31:0]      special_data;

  assign in_ready  = (count < CNT_FULL);
  assign push      = in_valid && in_ready;
  assign head      = mem[rd_ptr];
  assign fa_enable = (state == ISSUE);
  assign res_valid = (state == HOLD);
  assign state_dbg = state;

  // Special-case classification of the FIFO head. NaN/Inf wins over zero so
  // that 0 + Inf and 0 + NaN both produce the canonical quiet NaN.
  always_comb begin
    head_nan     = (head.a[30:23] == 8'hFF) || (head.b[30:23] == 8'hFF);
    head_a_zero  = (head.a[30:0] == 31'd0);
    head_b_zero  = (head.b[30:0] == 31'd0);
    head_special = head_nan || head_a_zero || head_b_zero;
    if (head_nan)
      special_data = QNAN;
    else if (head_a_zero)
      special_data = {head.b[31] ^ head.sub, head.b[30:0]};
    else
      special_data = head.a;
  end

  // FIFO storage carries no reset; validity is tracked by count/pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{a: in_a, b: in_b, sub: in_sub, tag: in_tag};
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop        = 1'b1;
          state_next = head_special ? HOLD : ISSUE;
        end
      end
      ISSUE:   state_next = CAPTURE;
      CAPTURE: state_next = HOLD;
      HOLD:    if (res_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand and result registers. The tag is latched at pop and stays put
  // through ISSUE/CAPTURE/HOLD; adder operands are only reloaded for
  // normal-path pairs so they hold their last value otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fa_a        <= '0;
      fa_b        <= '0;
      fa_negate   <= 1'b0;
      res_data    <= '0;
      res_tag     <= '0;
      res_special <= 1'b0;
    end else begin
      if (pop) begin
        res_tag <= head.tag;
        if (head_special) begin
          res_data    <= special_data;
          res_special <= 1'b1;
        end else begin
          fa_a      <= head.a;
          fa_b      <= head.b;
          fa_negate <= head.sub;
        end
      end
      if (state == CAPTURE) begin
        res_data    <= fa_out;
        res_special <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_float_add_sequencer.sv
module tb_float_add_sequencer;

  localparam int DEPTH = 4;
  localparam int TAG_W = 4;
  localparam logic [1:0] ST_CAPTURE = 2'd2;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   in_valid;
  logic                   in_ready;
  logic [31:0]            in_a, in_b;
  logic                   in_sub;
  logic [TAG_W-1:0]       in_tag;
  logic [31:0]            fa_a, fa_b;
  logic                   fa_negate, fa_enable;
  logic [31:0]            fa_out;
  logic                   res_valid, res_ready;
  logic [31:0]            res_data;
  logic [TAG_W-1:0]       res_tag;
  logic                   res_special;
  logic [$clog2(DEPTH):0] count;
  logic [1:0]             state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  // scoreboard: {special, tag, data}
  logic [36:0] exp_q[$];
  logic        sb_on = 1'b0;
  int          sb_matches = 0;

  int   en_cnt = 0;
  int   en_double = 0;
  logic en_prev = 1'b0;

  float_add_sequencer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_tag(in_tag),
    .fa_a(fa_a), .fa_b(fa_b), .fa_negate(fa_negate), .fa_enable(fa_enable),
    .fa_out(fa_out),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_tag(res_tag), .res_special(res_special),
    .count(count), .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- adder stand-in ----------------
  // Known float sums for the directed pairs; any other pair gives an
  // arbitrary but deterministic pattern. Outside an enable, fa_out is junk.
  function automatic logic [31:0] adder_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic neg);
    if (a == 32'h3F80_0000 && b == 32'h4000_0000 && !neg) return 32'h4040_0000;
    if (a == 32'h4040_0000 && b == 32'h3F80_0000 &&  neg) return 32'h4000_0000;
    if (a == 32'h3F80_0000 && b == 32'h3F80_0000 && !neg) return 32'h4000_0000;
    return a ^ {b[31] ^ neg, b[30:0]};
  endfunction

  always @(posedge clk) begin
    if (fa_enable) fa_out <= adder_model(fa_a, fa_b, fa_negate);
    else           fa_out <= $urandom;
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (fa_enable) en_cnt++;
    if (fa_enable && en_prev) en_double++;
    en_prev = fa_enable;
  end

  always @(negedge clk) begin
    if (sb_on && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_extra_result", 32'd1, 32'd0);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        check("sb_data", res_data, e[31:0]);
        check("sb_tag", {28'd0, res_tag}, {28'd0, e[35:32]});
        check("sb_special", {31'd0, res_special}, {31'd0, e[36]});
        sb_matches++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+#1; returns at posedge+#1 just after the push edge.
  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic sub,
                      input logic [TAG_W-1:0] tag);
    int n = 0;
    in_a = a; in_b = b; in_sub = sub; in_tag = tag; in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) check("push_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run_one(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic sub, input logic [TAG_W-1:0] tag,
                         input logic [31:0] exp_data, input logic exp_special,
                         input int exp_lat);
    int en0, lat;
    en0 = en_cnt;
    lat = 0;
    push(a, b, sub, tag);
    while (!res_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    check({name, "_latency"}, lat, exp_lat);
    check({name, "_data"}, res_data, exp_data);
    check({name, "_tag"}, {28'd0, res_tag}, {28'd0, tag});
    check({name, "_special"}, {31'd0, res_special}, {31'd0, exp_special});
    check({name, "_enables"}, en_cnt - en0, exp_special ? 0 : 1);
    if (!exp_special) begin
      check({name, "_fa_a"}, fa_a, a);
      check({name, "_fa_b"}, fa_b, b);
      check({name, "_fa_negate"}, {31'd0, fa_negate}, {31'd0, sub});
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check({name, "_valid_drops"}, {31'd0, res_valid}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic seen_valid;
    int   n;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; in_tag = '0;
    res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_res_valid", {31'd0, res_valid}, 32'd0);
    check("rst_count", {29'd0, count}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_fa_enable", {31'd0, fa_enable}, 32'd0);
    check("rst_res_data", res_data, 32'd0);
    check("rst_fa_a", fa_a, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // directed single operations
    run_one("add",      32'h3F80_0000, 32'h4000_0000, 1'b0, 4'h5, 32'h4040_0000, 1'b0, 3);
    run_one("sub",      32'h4040_0000, 32'h3F80_0000, 1'b1, 4'h6, 32'h4000_0000, 1'b0, 3);
    run_one("zero_a",   32'h0000_0000, 32'h40A0_0000, 1'b1, 4'h7, 32'hC0A0_0000, 1'b1, 1);
    run_one("inf",      32'h7F80_0000, 32'h3F80_0000, 1'b0, 4'h8, 32'h7FC0_0000, 1'b1, 1);
    run_one("zero_inf", 32'h0000_0000, 32'h7F80_0000, 1'b0, 4'h9, 32'h7FC0_0000, 1'b1, 1);
    run_one("zero_b",   32'h40A0_0000, 32'h8000_0000, 1'b1, 4'hA, 32'h40A0_0000, 1'b1, 1);
    run_one("denormal", 32'h0000_0001, 32'h3F80_0000, 1'b0, 4'hB, 32'h3F80_0001, 1'b0, 3);

    // backpressure: fill the FIFO behind one result held in HOLD
    res_ready = 1'b0;
    exp_q.push_back({1'b0, 4'h1, 32'h4000_0000});
    push(32'h3F80_0000, 32'h3F80_0000, 1'b0, 4'h1);
    exp_q.push_back({1'b1, 4'h2, 32'h40A0_0000});
    push(32'h40A0_0000, 32'h8000_0000, 1'b0, 4'h2);
    exp_q.push_back({1'b1, 4'h3, 32'h7FC0_0000});
    push(32'h3F80_0000, 32'hFF80_0001, 1'b0, 4'h3);
    exp_q.push_back({1'b0, 4'h4, 32'h4000_0000});
    push(32'h4040_0000, 32'h3F80_0000, 1'b1, 4'h4);
    exp_q.push_back({1'b1, 4'h5, 32'h3F80_0000});
    push(32'h8000_0000, 32'h3F80_0000, 1'b0, 4'h5);
    repeat (3) @(posedge clk);
    #1;
    check("bp_count_full", {29'd0, count}, 32'd4);
    check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    check("bp_res_valid", {31'd0, res_valid}, 32'd1);
    check("bp_head_tag", {28'd0, res_tag}, 32'd1);
    // sixth pair is offered but must be refused while full
    in_a = 32'h4000_0000; in_b = 32'h4000_0000; in_sub = 1'b0; in_tag = 4'h6;
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp_no_push_full", {29'd0, count}, 32'd4);
    sb_on = 1'b1;
    res_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk); n++;
    end
    @(posedge clk); #1;
    res_ready = 1'b0;
    sb_on = 1'b0;
    check("bp_drained", exp_q.size(), 0);
    check("bp_results", sb_matches, 5);
    check("bp_count_empty", {29'd0, count}, 32'd0);

    // reset in CAPTURE with two pairs queued
    push(32'h3F80_0000, 32'h4000_0000, 1'b0, 4'hC);
    push(32'h3F80_0000, 32'h3F80_0000, 1'b0, 4'hD);
    push(32'h4040_0000, 32'h3F80_0000, 1'b1, 4'hE);
    check("mid_state_capture", {30'd0, state_dbg}, {30'd0, ST_CAPTURE});
    check("mid_count", {29'd0, count}, 32'd2);
    rst = 1'b1;
    #1;
    check("mid_rst_res_valid", {31'd0, res_valid}, 32'd0);
    check("mid_rst_count", {29'd0, count}, 32'd0);
    check("mid_rst_fa_enable", {31'd0, fa_enable}, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    res_ready = 1'b1;
    seen_valid = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (res_valid) seen_valid = 1'b1;
    end
    res_ready = 1'b0;
    check("mid_no_result", {31'd0, seen_valid}, 32'd0);
    run_one("after_rst", 32'h3F80_0000, 32'h4000_0000, 1'b0, 4'h3, 32'h4040_0000, 1'b0, 3);

    check("enable_never_double", en_double, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
